// File: rtl/constants.sv
// Shared constants for the memory-mapped peripherals: timer register map,
// TAC rate encoding and timer FSM states.
package constants;

  localparam logic [15:0] ADDR_DIV  = 16'hFF04;
  localparam logic [15:0] ADDR_TIMA = 16'hFF05;
  localparam logic [15:0] ADDR_TMA  = 16'hFF06;
  localparam logic [15:0] ADDR_TAC  = 16'hFF07;

  typedef enum logic [1:0] {
    TAC_1024 = 2'b00,
    TAC_16   = 2'b01,
    TAC_64   = 2'b10,
    TAC_256  = 2'b11
  } tac_sel_t;

  typedef enum logic {
    TIMER_IDLE   = 1'b0,
    TIMER_RELOAD = 1'b1
  } timer_state_t;

  // Register index within the timer window (address offset from DIV).
  typedef enum logic [1:0] {
    REG_DIV  = 2'd0,
    REG_TIMA = 2'd1,
    REG_TMA  = 2'd2,
    REG_TAC  = 2'd3
  } timer_reg_t;

  // sys_cnt bit whose falling edge clocks TIMA for a given rate select.
  function automatic logic [3:0] tac_bit(input tac_sel_t sel);
    logic [3:0] idx;
    case (sel)
      TAC_1024: idx = 4'd9;
      TAC_16:   idx = 4'd3;
      TAC_64:   idx = 4'd5;
      TAC_256:  idx = 4'd7;
      default:  idx = 4'd9;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/timer_div.sv
// Free-running 16-bit system counter with synchronous clear, plus the
// TAC-selected falling-edge strobe that advances TIMA.
module timer_div
  import constants::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic [2:0] tac,
  output logic [7:0] div_value,
  output logic       inc
);

  logic [15:0] sys_cnt;
  logic        timer_in;
  logic        timer_in_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys_cnt <= '0;
    end else if (clr) begin
      sys_cnt <= '0;
    end else begin
      sys_cnt <= sys_cnt + 16'd1;
    end
  end

  // Gating with TAC[2] before the edge detector is what produces the
  // intentional extra increments on DIV clear / TAC changes.
  always_comb begin
    timer_in = tac[2] & sys_cnt[tac_bit(tac_sel_t'(tac[1:0]))];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_in_d <= 1'b0;
    end else begin
      timer_in_d <= timer_in;
    end
  end

  assign inc       = timer_in_d & ~timer_in;
  assign div_value = sys_cnt[15:8];

endmodule

// File: rtl/timer_unit.sv
// Timer peripheral at BASE_ADDR..BASE_ADDR+3 (DIV, TIMA, TMA, TAC) on the
// shared tri-state CPU bus; raises a one-cycle irq on TIMA overflow.
module timer_unit
  import constants::*;
#(
  parameter logic [15:0] BASE_ADDR = ADDR_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  inout  tri   [7:0]  databus,
  input  logic        RE,
  input  logic        WE,
  output logic        irq_timer
);

  logic [15:0]  offset;
  logic         hit;
  timer_reg_t   reg_sel;
  logic [7:0]   wdata;
  logic [7:0]   rdata;
  logic         wr_div, wr_tima, wr_tma, wr_tac;

  logic [7:0]   tima, tima_n;
  logic [7:0]   tma;
  logic [2:0]   tac;
  logic [7:0]   div_value;
  logic         inc;
  logic         irq_n;
  timer_state_t state, state_n;

  assign offset  = address - BASE_ADDR;
  assign hit     = (offset[15:2] == '0);
  assign reg_sel = timer_reg_t'(offset[1:0]);
  assign wdata   = databus;

  assign wr_div  = WE & hit & (reg_sel == REG_DIV);
  assign wr_tima = WE & hit & (reg_sel == REG_TIMA);
  assign wr_tma  = WE & hit & (reg_sel == REG_TMA);
  assign wr_tac  = WE & hit & (reg_sel == REG_TAC);

  timer_div u_div (
    .clk       (clk),
    .rst       (rst),
    .clr       (wr_div),
    .tac       (tac),
    .div_value (div_value),
    .inc       (inc)
  );

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_DIV:  rdata = div_value;
      REG_TIMA: rdata = tima;
      REG_TMA:  rdata = tma;
      REG_TAC:  rdata = {5'b11111, tac};
      default:  rdata = '0;
    endcase
  end

  assign databus = (RE && hit) ? rdata : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tma <= '0;
      tac <= '0;
    end else begin
      if (wr_tma) tma <= wdata;
      if (wr_tac) tac <= wdata[2:0];
    end
  end

  // A CPU write to TIMA always takes priority; during RELOAD it also
  // cancels the reload and the interrupt.
  always_comb begin
    state_n = state;
    tima_n  = tima;
    irq_n   = 1'b0;
    case (state)
      TIMER_IDLE: begin
        if (wr_tima) begin
          tima_n = wdata;
        end else if (inc) begin
          if (tima == 8'hFF) begin
            tima_n  = 8'h00;
            state_n = TIMER_RELOAD;
          end else begin
            tima_n = tima + 8'd1;
          end
        end
      end
      TIMER_RELOAD: begin
        state_n = TIMER_IDLE;
        if (wr_tima) begin
          tima_n = wdata;
        end else begin
          tima_n = wr_tma ? wdata : tma;
          irq_n  = 1'b1;
        end
      end
      default: state_n = TIMER_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= TIMER_IDLE;
      tima      <= '0;
      irq_timer <= 1'b0;
    end else begin
      state     <= state_n;
      tima      <= tima_n;
      irq_timer <= irq_n;
    end
  end

endmodule

// File: tb/tb_timer_unit.sv
// Directed bench for timer_unit: stimulus queues expected bus/irq values,
// a negedge monitor pops and compares whenever a read or probe is active.
module tb_timer_unit;

  logic        clk;
  logic        rst;
  logic [15:0] address;
  tri   [7:0]  databus;
  logic        RE;
  logic        WE;
  logic        irq_timer;

  logic        tb_oe;
  logic [7:0]  tb_data;
  logic        probe;

  int checks;
  int failures;

  typedef struct {
    string      name;
    logic [7:0] data;
    bit         chk_irq;
    bit         irq;
  } exp_t;

  exp_t exp_q[$];

  assign databus = tb_oe ? tb_data : 'z;

  // Weak pull-ups make an undriven bus read back as 8'hFF.
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (databus[i]);
  end

  timer_unit #(.BASE_ADDR(16'hFF04)) dut (
    .clk       (clk),
    .rst       (rst),
    .address   (address),
    .databus   (databus),
    .RE        (RE),
    .WE        (WE),
    .irq_timer (irq_timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic irq_prev = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (irq_timer) begin
      checks++;
      if (irq_prev) begin
        failures++;
        $display("FAIL irq_consecutive: irq_timer high two cycles in a row at %0t", $time);
      end
    end
    irq_prev = irq_timer;
    if (RE || probe) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_read: addr=%h data=%h with no expectation", address, databus);
      end else begin
        e = exp_q.pop_front();
        if (databus !== e.data) begin
          failures++;
          $display("FAIL %s: databus=%h expected=%h", e.name, databus, e.data);
        end
        if (e.chk_irq) begin
          checks++;
          if (irq_timer !== e.irq) begin
            failures++;
            $display("FAIL %s_irq: irq_timer=%b expected=%b", e.name, irq_timer, e.irq);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address = a;
    tb_data = d;
    tb_oe   = 1'b1;
    WE      = 1'b1;
    step();
    WE      = 1'b0;
    tb_oe   = 1'b0;
    address = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] d, input string nm,
                    input bit ci = 1'b0, input bit iv = 1'b0);
    exp_t e;
    e.name = nm; e.data = d; e.chk_irq = ci; e.irq = iv;
    exp_q.push_back(e);
    address = a;
    RE      = 1'b1;
    step();
    RE      = 1'b0;
    address = 16'h0000;
  endtask

  task automatic float_probe(input logic [15:0] a, input string nm);
    exp_t e;
    e.name = nm; e.data = 8'hFF; e.chk_irq = 1'b0; e.irq = 1'b0;
    exp_q.push_back(e);
    address = a;
    probe   = 1'b1;
    step();
    probe   = 1'b0;
    address = 16'h0000;
  endtask

  // Stop the timer, zero sys_cnt, preload TMA/TIMA, then enable TAC=0x05;
  // the first TIMA increment then lands exactly 14 idle cycles later.
  task automatic arm(input logic [7:0] tma_v, input logic [7:0] tima_v);
    wr(16'hFF07, 8'h00);
    wr(16'hFF04, 8'h00);
    wr(16'hFF06, tma_v);
    wr(16'hFF05, tima_v);
    wr(16'hFF07, 8'h05);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; address = '0; RE = 1'b0; WE = 1'b0;
    tb_oe = 1'b0; tb_data = '0; probe = 1'b0;
    idle(3);
    rst = 1'b0;

    float_probe(16'hFF05, "float_re0");
    rd(16'hFF04, 8'h00, "rst_div");
    rd(16'hFF05, 8'h00, "rst_tima");
    rd(16'hFF06, 8'h00, "rst_tma");
    rd(16'hFF07, 8'hF8, "rst_tac");

    // Counting: increments at edges 17, 33, ... after the DIV clear.
    wr(16'hFF04, 8'h00);
    wr(16'hFF07, 8'h05);
    wr(16'hFF05, 8'h10);
    idle(14);
    rd(16'hFF05, 8'h10, "cnt_before1");
    rd(16'hFF05, 8'h11, "cnt_after1");
    idle(14);
    rd(16'hFF05, 8'h11, "cnt_before2");
    rd(16'hFF05, 8'h12, "cnt_after2");
    idle(126);
    rd(16'hFF05, 8'h19, "cnt_before10");
    rd(16'hFF05, 8'h1A, "cnt_after10");

    // Overflow FE -> FF -> 00 -> TMA.
    arm(8'hAB, 8'hFE);
    idle(29);
    rd(16'hFF05, 8'hFF, "ovf_ff", 1'b1, 1'b0);
    rd(16'hFF05, 8'h00, "ovf_zero", 1'b1, 1'b0);
    rd(16'hFF05, 8'hAB, "ovf_reload", 1'b1, 1'b1);
    rd(16'hFF05, 8'hAB, "ovf_after", 1'b1, 1'b0);

    // TIMA write during RELOAD cancels reload and irq.
    arm(8'hAB, 8'hFF);
    idle(14);
    wr(16'hFF05, 8'h42);
    rd(16'hFF05, 8'h42, "cancel_tima", 1'b1, 1'b0);

    // TMA write during RELOAD is what gets loaded.
    arm(8'hAB, 8'hFF);
    idle(14);
    wr(16'hFF06, 8'h77);
    rd(16'hFF05, 8'h77, "reload_new_tma", 1'b1, 1'b1);
    rd(16'hFF06, 8'h77, "tma_written", 1'b1, 1'b0);

    // Reset asserted during RELOAD: no irq, all registers back to reset.
    arm(8'hAB, 8'hFF);
    idle(14);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd(16'hFF05, 8'h00, "midrst_tima", 1'b1, 1'b0);
    rd(16'hFF05, 8'h00, "midrst_tima2", 1'b1, 1'b0);
    rd(16'hFF04, 8'h00, "midrst_div");
    rd(16'hFF06, 8'h00, "midrst_tma");
    rd(16'hFF07, 8'hF8, "midrst_tac");

    // Address decode: writes outside the window are ignored, reads float.
    wr(16'hFF08, 8'h3C);
    wr(16'hFF09, 8'h3C);
    wr(16'hFF0B, 8'h3C);
    wr(16'hFF03, 8'h3C);
    rd(16'hFF05, 8'h00, "dec_tima");
    rd(16'hFF06, 8'h00, "dec_tma");
    rd(16'hFF07, 8'hF8, "dec_tac");
    rd(16'hFF03, 8'hFF, "dec_float_ff03");
    rd(16'hFF08, 8'hFF, "dec_float_ff08");

    // DIV clear at sys_cnt = 0x1234.
    wr(16'hFF07, 8'h00);
    wr(16'hFF04, 8'h00);
    idle(16'h1233);
    rd(16'hFF04, 8'h12, "div_1233");
    wr(16'hFF04, 8'h99);
    rd(16'hFF04, 8'h00, "div_cleared");

    // DIV clear while sys_cnt[3]=1 with TAC=0x05 gives one extra increment.
    wr(16'hFF05, 8'h50);
    wr(16'hFF07, 8'h05);
    idle(7);
    wr(16'hFF04, 8'h00);
    rd(16'hFF05, 8'h50, "glitch_before");
    rd(16'hFF05, 8'h51, "glitch_after");

    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_unit.md
# timer_unit

Memory-mapped timer peripheral that responds on the CPU's memory bus at 0xFF04–0xFF07 (DIV, TIMA, TMA, TAC). It shares the `address`/`databus`/`RE`/`WE` bus with `sram`, answering reads and writes only for its own four addresses. It keeps a free-running 16-bit system counter and increments TIMA at the TAC-selected rate. On TIMA overflow it reloads TIMA from TMA and raises a one-cycle timer interrupt request.

## Interface
- `BASE_ADDR`, default 16'hFF04: address of DIV; TIMA, TMA and TAC sit at +1, +2 and +3.
- `clk`  input  1  system clock; the only clock.
- `rst`  input  1  reset, asynchronous, active-high.
- `address`  input  16  bus address, driven by the CPU MAR.
- `databus`  inout (tri)  8  shared data bus.
- `RE`  input  1  read enable.
- `WE`  input  1  write enable.
- `irq_timer`  output  1  one-cycle interrupt request pulse, registered.

## Operation
- A register hit means `address` is in BASE_ADDR..BASE_ADDR+3.
- **Reads** are combinational. When `RE` is high and the address hits, the block drives `databus`; otherwise it leaves `databus` at high-Z.
  - DIV reads sys_cnt[15:8].
  - TAC reads {5'b11111, TAC[2:0]}.
- **Writes** are captured at the clk edge when `WE` is high and the address hits.
  - DIV: any written value clears sys_cnt to 0.
  - TAC: stores data[2:0] only.
- sys_cnt increments by 1 every clock, wrapping at 0xFFFF to 0x0000.
- Timer input is timer_in = TAC[2] & sys_cnt[bit]. The bit depends on TAC[1:0]:
  - 00 selects bit 9 (period 1024 clocks).
  - 01 selects bit 3 (period 16).
  - 10 selects bit 5 (period 64).
  - 11 selects bit 7 (period 256).
- timer_in_d is a register copy of timer_in. inc = timer_in_d & ~timer_in, i.e. a falling-edge detect. When inc is high, TIMA increments at that edge.
- Glitch increments are intentional:
  - Clearing DIV while the selected bit is 1 causes an extra increment.
  - Clearing TAC[2] while the selected bit is 1 causes an extra increment.
  - Changing TAC[1:0] from a selected bit at 1 to one at 0 causes an extra increment.
- State machine `timer_state_t`:
  - IDLE: if inc occurs with TIMA=0xFF, TIMA <= 0x00 and the state goes to RELOAD.
  - RELOAD, always one cycle: TIMA <= TMA, irq_timer <= 1, then return to IDLE.
- Simultaneous events:
  - A TIMA write in the same cycle as inc: the write wins and there is no increment.
  - A TIMA write during RELOAD: the written value is kept, the reload and the irq are cancelled, and the state returns to IDLE.
  - A TMA write during RELOAD: TIMA loads the newly written value.
  - A DIV write and the sys_cnt increment in the same cycle: sys_cnt = 0.
- Reset values:
  - sys_cnt=0, TIMA=0, TMA=0, TAC=0.
  - timer_in_d=0, state=IDLE, irq_timer=0.
  - `databus` at high-Z.
- Reset asserted during RELOAD aborts the reload with no irq.

## Timing
- Read latency is 0. Data is valid on `databus` in the same cycle `RE` is high, so the CPU latches it into MDR at that edge.
- Write latency is 1. The new value is visible to reads from the cycle after the `WE` edge.
- TIMA increment: one cycle after the edge where sys_cnt's selected bit goes 1→0. With TAC=3'b101, increments are exactly 16 clocks apart.
- Overflow sequence:
  - Edge N: TIMA 0xFF→0x00.
  - Edge N+1: TIMA←TMA, and `irq_timer` goes high.
  - Edge N+2: `irq_timer` goes low.
- `irq_timer` is never high for two consecutive cycles.

## Structure
- Add to the shared `constants.sv` package:
  - ADDR_DIV, ADDR_TIMA, ADDR_TMA, ADDR_TAC.
  - Enum `tac_sel_t` (TAC_1024, TAC_16, TAC_64, TAC_256).
  - Enum `timer_state_t` (TIMER_IDLE, TIMER_RELOAD).
- One sub-module, `timer_div`. It holds the 16-bit sys_cnt with a synchronous clear input, and produces the TAC-selected falling-edge strobe `inc` (owning timer_in_d).
- The top level owns the bus decode, the tri-state drive, TIMA/TMA/TAC, the FSM and `irq_timer`.

## Test plan
- **Reset:** assert rst mid-run → all register reads return 0x00, except TAC which reads 0xF8; `databus` is Z while RE=0.
- **Counting:** write TAC=0x05 and TIMA=0x10, run 160 clocks → TIMA=0x1A, with increments 16 clocks apart.
- **Overflow:** write TMA=0xAB, TIMA=0xFE, TAC=0x05 → two increments later TIMA reads 0x00 for 1 cycle, then 0xAB; `irq_timer` is high exactly 1 cycle, coincident with TIMA=0xAB.
- **Cancelled reload:** write TIMA=0x42 during the RELOAD cycle → TIMA=0x42 and `irq_timer` stays 0. Separately, write TMA=0x77 during RELOAD → TIMA=0x77.
- **DIV clear:** run to sys_cnt=0x1234, write DIV=0x99 → DIV reads 0x00. With TAC=0x05 and sys_cnt[3]=1 at the write, TIMA gets +1 one cycle later.
- **Address decode:** RE=1 at 0xFF03 and at 0xFF08 → `databus` is Z. WE=1 at 0xFF08 → no register changes.
